// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the MEM stage and the system bus.
// Accepts one access per handshake, range/alignment/width checks it against
// NUM_DEV address windows, and either reports an address fault directly or
// runs a single word-aligned, byte-enabled bus transaction with a timeout.
// Every output is driven from a flop; the combinational process computes the
// value each output takes after the next clock edge.
module lsu_bus_bridge #(
  parameter int                     NUM_DEV       = 3,
  parameter logic [NUM_DEV*32-1:0]  DEV_BASE      = {32'h0000_7f10, 32'h0000_7f00, 32'h0000_0000},
  parameter logic [NUM_DEV*32-1:0]  DEV_END       = {32'h0000_7f1b, 32'h0000_7f0b, 32'h0000_2fff},
  parameter logic [NUM_DEV-1:0]     DEV_WORD_ONLY = 3'b110,
  parameter int                     TIMEOUT       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_op,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               bus_valid,
  output logic               bus_we,
  output logic [31:0]        bus_addr,
  output logic [3:0]         bus_be,
  output logic [31:0]        bus_wdata,
  output logic [NUM_DEV-1:0] bus_sel,
  input  logic               bus_ack,
  input  logic [31:0]        bus_rdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic [1:0]         rsp_exc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_WORD   = 3'b000;
  localparam logic [2:0] OP_BYTE_U = 3'b001;
  localparam logic [2:0] OP_BYTE_S = 3'b010;
  localparam logic [2:0] OP_HALF_U = 3'b011;
  localparam logic [2:0] OP_HALF_S = 3'b100;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ADEL    = 2'b01;
  localparam logic [1:0] EXC_ADES    = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT = 2'b11;

  // Counter only has to reach TIMEOUT-1: the TIMEOUT-th unacked cycle ends the wait.
  localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Byte lanes touched by an access of the given op at the given byte offset.
  function automatic logic [3:0] byte_enables(input logic [2:0] op, input logic [1:0] ofs);
    case (op)
      OP_WORD:              byte_enables = 4'b1111;
      OP_BYTE_U, OP_BYTE_S: byte_enables = 4'b0001 << ofs;
      OP_HALF_U, OP_HALF_S: byte_enables = 4'b0011 << ofs;
      default:              byte_enables = 4'b0000;
    endcase
  endfunction

  // Replicate sub-word store data so every enabled lane carries it.
  function automatic logic [31:0] replicate(input logic [2:0] op, input logic [31:0] data);
    case (op)
      OP_BYTE_U, OP_BYTE_S: replicate = {4{data[7:0]}};
      OP_HALF_U, OP_HALF_S: replicate = {2{data[15:0]}};
      default:              replicate = data;
    endcase
  endfunction

  // Pick the addressed lane out of the bus word and zero/sign-extend it.
  function automatic logic [31:0] extend_load(input logic [2:0] op, input logic [1:0] ofs,
                                              input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {ofs, 3'b000};
    case (op)
      OP_WORD:   extend_load = word;
      OP_BYTE_U: extend_load = {24'h00_0000, shifted[7:0]};
      OP_BYTE_S: extend_load = {{24{shifted[7]}}, shifted[7:0]};
      OP_HALF_U: extend_load = {16'h0000, shifted[15:0]};
      OP_HALF_S: extend_load = {{16{shifted[15]}}, shifted[15:0]};
      default:   extend_load = 32'h0000_0000;
    endcase
  endfunction

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [2:0]         op_r, op_s;
  logic [1:0]         ofs_r, ofs_s;

  logic [NUM_DEV-1:0] hit_sel_s;
  logic               hit_any_s;
  logic               misaligned_s;
  logic               width_fault_s;
  logic               fault_s;

  logic               req_ready_s;
  logic               bus_valid_s;
  logic               bus_we_s;
  logic [31:0]        bus_addr_s;
  logic [3:0]         bus_be_s;
  logic [31:0]        bus_wdata_s;
  logic [NUM_DEV-1:0] bus_sel_s;
  logic               rsp_valid_s;
  logic [31:0]        rsp_rdata_s;
  logic [1:0]         rsp_exc_s;

  // Window decode (lowest index wins on overlap) and fault classification of the request.
  always_comb begin
    hit_sel_s = '0;
    hit_any_s = 1'b0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (!hit_any_s && (req_addr >= DEV_BASE[i*32 +: 32]) && (req_addr <= DEV_END[i*32 +: 32])) begin
        hit_sel_s[i] = 1'b1;
        hit_any_s    = 1'b1;
      end else begin
        hit_sel_s[i] = 1'b0;
      end
    end

    case (req_op)
      OP_WORD:              misaligned_s = (req_addr[1:0] != 2'b00);
      OP_BYTE_U, OP_BYTE_S: misaligned_s = 1'b0;
      OP_HALF_U, OP_HALF_S: misaligned_s = req_addr[0];
      default:              misaligned_s = 1'b1;  // reserved ops fault like misalignment
    endcase

    width_fault_s = (req_op != OP_WORD) && (|(hit_sel_s & DEV_WORD_ONLY));
    fault_s       = misaligned_s || !hit_any_s || width_fault_s;
  end

  // Next-state and next-output logic for the IDLE/BUS/RESP sequencer.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    op_s        = op_r;
    ofs_s       = ofs_r;
    req_ready_s = 1'b0;
    bus_valid_s = 1'b0;
    bus_we_s    = 1'b0;
    bus_addr_s  = 32'h0000_0000;
    bus_be_s    = 4'b0000;
    bus_wdata_s = 32'h0000_0000;
    bus_sel_s   = '0;
    rsp_valid_s = 1'b0;
    rsp_rdata_s = 32'h0000_0000;
    rsp_exc_s   = EXC_NONE;

    case (state_r)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_s  = req_op;
          ofs_s = req_addr[1:0];
          cnt_s = CNT_ZERO;
          if (fault_s) begin
            state_s     = RESP;
            rsp_valid_s = 1'b1;
            rsp_exc_s   = req_we ? EXC_ADES : EXC_ADEL;
          end else begin
            state_s     = BUS;
            bus_valid_s = 1'b1;
            bus_we_s    = req_we;
            bus_addr_s  = {req_addr[31:2], 2'b00};
            bus_be_s    = byte_enables(req_op, req_addr[1:0]);
            bus_wdata_s = replicate(req_op, req_wdata);
            bus_sel_s   = hit_sel_s;
          end
        end else begin
          req_ready_s = 1'b1;
        end
      end

      BUS: begin
        if (bus_ack) begin
          state_s     = RESP;
          cnt_s       = CNT_ZERO;
          rsp_valid_s = 1'b1;
          rsp_exc_s   = EXC_NONE;
          rsp_rdata_s = bus_we ? 32'h0000_0000 : extend_load(op_r, ofs_r, bus_rdata);
        end else if (cnt_r == CNT_LAST) begin
          state_s     = RESP;
          cnt_s       = CNT_ZERO;
          rsp_valid_s = 1'b1;
          rsp_exc_s   = EXC_TIMEOUT;
        end else begin
          cnt_s       = cnt_r + CNT_ONE;
          bus_valid_s = bus_valid;
          bus_we_s    = bus_we;
          bus_addr_s  = bus_addr;
          bus_be_s    = bus_be;
          bus_wdata_s = bus_wdata;
          bus_sel_s   = bus_sel;
        end
      end

      RESP: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
      end

      default: begin
        state_s     = IDLE;
        cnt_s       = CNT_ZERO;
        req_ready_s = 1'b1;
      end
    endcase
  end

  // State, bookkeeping and output registers; reset abandons any transaction silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      op_r      <= 3'b000;
      ofs_r     <= 2'b00;
      req_ready <= 1'b1;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0000_0000;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0000_0000;
      bus_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_exc   <= EXC_NONE;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      op_r      <= op_s;
      ofs_r     <= ofs_s;
      req_ready <= req_ready_s;
      bus_valid <= bus_valid_s;
      bus_we    <= bus_we_s;
      bus_addr  <= bus_addr_s;
      bus_be    <= bus_be_s;
      bus_wdata <= bus_wdata_s;
      bus_sel   <= bus_sel_s;
      rsp_valid <= rsp_valid_s;
      rsp_rdata <= rsp_rdata_s;
      rsp_exc   <= rsp_exc_s;
    end
  end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge: a size/offset-based reference model
// predicts bus and response values, a compare process checks them every cycle,
// and directed vectors pin latencies and literal results.
module tb_lsu_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        bus_valid, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic [2:0]  bus_sel;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_exc;

  lsu_bus_bridge dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_exc(rsp_exc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wbase [3] = '{32'h0000_0000, 32'h0000_7f00, 32'h0000_7f10};
  logic [31:0] wend  [3] = '{32'h0000_2fff, 32'h0000_7f0b, 32'h0000_7f1b};
  logic        wword [3] = '{1'b0, 1'b1, 1'b1};

  typedef struct { logic [31:0] rd; logic [1:0] exc; } rsp_t;
  rsp_t rsp_q[$];

  logic        exp_bus_active = 1'b0;
  logic        exp_bus_we;
  logic [31:0] exp_bus_addr, exp_bus_wdata;
  logic [3:0]  exp_bus_be;
  logic [2:0]  exp_bus_sel;

  logic [31:0] obs_rd, obs_addr, obs_wdata;
  logic [1:0]  obs_exc;
  logic [3:0]  obs_be;
  logic [2:0]  obs_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what a single access must produce, from access size and offset.
  function automatic void model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                output logic go, output logic [3:0] be, output logic [31:0] baddr,
                                output logic [31:0] bwd, output logic [2:0] sel,
                                output logic [31:0] rd, output logic [1:0] exc);
    int size, idx, m, ofs;
    logic hit, aligned;
    logic [31:0] lane;
    size = 0;
    if (op == 3'd0) size = 4;
    else if (op == 3'd1 || op == 3'd2) size = 1;
    else if (op == 3'd3 || op == 3'd4) size = 2;
    ofs = int'(addr[1:0]);
    hit = 1'b0;
    idx = 0;
    for (int i = 2; i >= 0; i--)
      if (addr >= wbase[i] && addr <= wend[i]) begin hit = 1'b1; idx = i; end
    aligned = 1'b0;
    if (size != 0) aligned = ((ofs % size) == 0);
    go    = aligned && hit && !(size != 4 && wword[idx]);
    exc   = go ? 2'b00 : (we ? 2'b10 : 2'b01);
    m     = 1 << idx;
    sel   = m[2:0];
    baddr = addr & 32'hFFFF_FFFC;
    m     = ((1 << size) - 1) << ofs;
    be    = m[3:0];
    if (size == 1)      bwd = wdata[7:0] * 32'h0101_0101;
    else if (size == 2) bwd = wdata[15:0] * 32'h0001_0001;
    else                bwd = wdata;
    lane = rdata >> (8 * ofs);
    rd   = lane;
    if (size == 1) begin
      rd = lane & 32'h0000_00FF;
      if (op == 3'd2 && rd >= 32'h0000_0080) rd = rd + 32'hFFFF_FF00;
    end
    if (size == 2) begin
      rd = lane & 32'h0000_FFFF;
      if (op == 3'd4 && rd >= 32'h0000_8000) rd = rd + 32'hFFFF_0000;
    end
    if (we || !go) rd = 32'h0000_0000;
  endfunction

  // Per-cycle comparison of bus and response outputs against the model's expectations.
  always @(negedge clk) begin
    rsp_t e;
    if (!reset) begin
      if (bus_valid) begin
        chk("bus_valid_expected", {31'b0, exp_bus_active}, 32'd1);
        chk("bus_we",    {31'b0, bus_we},  {31'b0, exp_bus_we});
        chk("bus_addr",  bus_addr,         exp_bus_addr);
        chk("bus_be",    {28'b0, bus_be},  {28'b0, exp_bus_be});
        chk("bus_wdata", bus_wdata,        exp_bus_wdata);
        chk("bus_sel",   {29'b0, bus_sel}, {29'b0, exp_bus_sel});
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=1, expected no response (t=%0t)", $time);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rd);
          chk("rsp_exc", {30'b0, rsp_exc}, {30'b0, e.exc});
        end
      end else begin
        chk("rsp_rdata_idle", rsp_rdata, 32'h0);
        chk("rsp_exc_idle", {30'b0, rsp_exc}, 32'h0);
      end
    end
  end

  // Issue one request at a negedge, serve the bus, and measure latency and bus cycles.
  task automatic run_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int ack_after,
                         output int lat, output int bv);
    logic go;
    logic [3:0] be;
    logic [31:0] ba, bw, rd;
    logic [2:0] sel;
    logic [1:0] exc;
    rsp_t e;
    bit done;
    model(we, op, addr, wdata, rdata, go, be, ba, bw, sel, rd, exc);
    if (go && ack_after < 0) begin rd = 32'h0; exc = 2'b11; end
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    exp_bus_active = go;
    exp_bus_we = we; exp_bus_addr = ba; exp_bus_be = be; exp_bus_wdata = bw; exp_bus_sel = sel;
    e.rd = rd; e.exc = exc;
    rsp_q.push_back(e);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    bus_rdata = rdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; bv = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (rsp_valid) begin
        done = 1'b1; lat = k + 1; obs_rd = rsp_rdata; obs_exc = rsp_exc;
      end else begin
        chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
        if (bus_valid) begin
          bv++;
          obs_be = bus_be; obs_sel = bus_sel; obs_addr = bus_addr; obs_wdata = bus_wdata;
        end
        bus_ack = bus_valid && (ack_after >= 0) && (bv == ack_after + 1);
        @(negedge clk);
      end
    end
    bus_ack = 1'b0;
    exp_bus_active = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL rsp_wait: no rsp_valid within 40 cycles for addr %h", addr);
      rsp_q.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic we; logic [2:0] op; logic [31:0] addr, wdata, rdata; int ack;
    int lat; logic [1:0] exc; logic [31:0] rd; logic [3:0] be; logic [2:0] sel; logic [31:0] bwd;
  } vec_t;

  vec_t vecs [18];

  initial begin
    int lat, bv;
    int rdy [6];
    int rv [6];
    logic go;
    logic [3:0] be;
    logic [31:0] ba, bw, rd;
    logic [2:0] sel;
    logic [1:0] exc;
    rsp_t e;

    vecs[0]  = '{1'b0, 3'd2, 32'h0000_0003, 32'h0,         32'h80AB_CD12, 0,  2,  2'b00, 32'hFFFF_FF80, 4'b1000, 3'b001, 32'h0};
    vecs[1]  = '{1'b1, 3'd3, 32'h0000_0102, 32'h1234_BEEF, 32'h0,         0,  2,  2'b00, 32'h0,         4'b1100, 3'b001, 32'hBEEF_BEEF};
    vecs[2]  = '{1'b0, 3'd0, 32'h0000_0006, 32'h0,         32'h0,         0,  1,  2'b01, 32'h0,         4'b0000, 3'b000, 32'h0};
    vecs[3]  = '{1'b1, 3'd0, 32'h0000_3000, 32'h1111_2222, 32'h0,         0,  1,  2'b10, 32'h0,         4'b0000, 3'b000, 32'h0};
    vecs[4]  = '{1'b0, 3'd1, 32'h0000_7f04, 32'h0,         32'h0,         0,  1,  2'b01, 32'h0,         4'b0000, 3'b000, 32'h0};
    vecs[5]  = '{1'b0, 3'd0, 32'h0000_7f14, 32'h0,         32'h1234_5678, -1, 17, 2'b11, 32'h0,         4'b1111, 3'b100, 32'h0};
    vecs[6]  = '{1'b0, 3'd1, 32'h0000_0102, 32'h0,         32'h1122_3344, 2,  4,  2'b00, 32'h0000_0022, 4'b0100, 3'b001, 32'h0};
    vecs[7]  = '{1'b0, 3'd4, 32'h0000_0002, 32'h0,         32'h8001_1234, 0,  2,  2'b00, 32'hFFFF_8001, 4'b1100, 3'b001, 32'h0};
    vecs[8]  = '{1'b0, 3'd3, 32'h0000_0000, 32'h0,         32'h8001_1234, 1,  3,  2'b00, 32'h0000_1234, 4'b0011, 3'b001, 32'h0};
    vecs[9]  = '{1'b1, 3'd1, 32'h0000_0007, 32'h0000_00AB, 32'hFFFF_FFFF, 0,  2,  2'b00, 32'h0,         4'b1000, 3'b001, 32'hABAB_ABAB};
    vecs[10] = '{1'b1, 3'd0, 32'h0000_7f08, 32'h55AA_0FF0, 32'h0,         0,  2,  2'b00, 32'h0,         4'b1111, 3'b010, 32'h55AA_0FF0};
    vecs[11] = '{1'b0, 3'd5, 32'h0000_0000, 32'h0,         32'h0,         0,  1,  2'b01, 32'h0,         4'b0000, 3'b000, 32'h0};
    vecs[12] = '{1'b0, 3'd3, 32'h0000_0001, 32'h0,         32'h0,         0,  1,  2'b01, 32'h0,         4'b0000, 3'b000, 32'h0};
    vecs[13] = '{1'b0, 3'd0, 32'h0000_7f1c, 32'h0,         32'h0,         0,  1,  2'b01, 32'h0,         4'b0000, 3'b000, 32'h0};
    vecs[14] = '{1'b1, 3'd1, 32'h0000_7f10, 32'h0000_0042, 32'h0,         0,  1,  2'b10, 32'h0,         4'b0000, 3'b000, 32'h0};
    vecs[15] = '{1'b0, 3'd0, 32'h0000_2ffc, 32'h0,         32'hDEAD_BEEF, 15, 17, 2'b00, 32'hDEAD_BEEF, 4'b1111, 3'b001, 32'h0};
    vecs[16] = '{1'b0, 3'd2, 32'h0000_2fff, 32'h0,         32'h7F00_0000, 0,  2,  2'b00, 32'h0000_007F, 4'b1000, 3'b001, 32'h0};
    vecs[17] = '{1'b0, 3'd0, 32'h0000_7f0c, 32'h0,         32'h0,         0,  1,  2'b01, 32'h0,         4'b0000, 3'b000, 32'h0};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h0;
    req_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_bus_valid", {31'b0, bus_valid}, 32'd0);
    chk("reset_bus_sel",   {29'b0, bus_sel},   32'd0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_req(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].ack, lat, bv);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_rsp_exc", i), {30'b0, obs_exc}, {30'b0, vecs[i].exc});
      chk($sformatf("v%0d_rsp_rdata", i), obs_rd, vecs[i].rd);
      if (vecs[i].lat == 1) begin
        chk($sformatf("v%0d_no_bus", i), 32'(bv), 32'd0);
      end else begin
        chk($sformatf("v%0d_bus_cycles", i), 32'(bv), (vecs[i].ack < 0) ? 32'd16 : 32'(vecs[i].ack + 1));
        chk($sformatf("v%0d_bus_be", i), {28'b0, obs_be}, {28'b0, vecs[i].be});
        chk($sformatf("v%0d_bus_sel", i), {29'b0, obs_sel}, {29'b0, vecs[i].sel});
        chk($sformatf("v%0d_bus_addr", i), obs_addr, vecs[i].addr & 32'hFFFF_FFFC);
        if (vecs[i].we) chk($sformatf("v%0d_bus_wdata", i), obs_wdata, vecs[i].bwd);
      end
      if (vecs[i].ack < 0) begin
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("late_ack_ready", {31'b0, req_ready}, 32'd1);
        chk("late_ack_no_bus", {31'b0, bus_valid}, 32'd0);
        @(negedge clk);
      end
    end

    // Reset in the middle of a bus transaction: abandoned, no response.
    model(1'b0, 3'd0, 32'h0000_0100, 32'h0, 32'h0, go, be, ba, bw, sel, rd, exc);
    exp_bus_active = go; exp_bus_we = 1'b0; exp_bus_addr = ba; exp_bus_be = be;
    exp_bus_wdata = bw; exp_bus_sel = sel;
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h0000_0100; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_bus_valid", {31'b0, bus_valid}, 32'd1);
    #2;
    exp_bus_active = 1'b0;
    reset = 1'b1;
    #1;
    chk("midreset_bus_valid", {31'b0, bus_valid}, 32'd0);
    chk("midreset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midreset_bus_sel",   {29'b0, bus_sel},   32'd0);
    chk("midreset_bus_be",    {28'b0, bus_be},    32'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_reset_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    run_req(1'b0, 3'd0, 32'h0000_0200, 32'h0, 32'hA5A5_5A5A, 0, lat, bv);
    chk("post_reset_latency", 32'(lat), 32'd2);
    chk("post_reset_rdata", obs_rd, 32'hA5A5_5A5A);

    // Back-to-back: req_valid held high across two identical loads.
    model(1'b0, 3'd0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, go, be, ba, bw, sel, rd, exc);
    exp_bus_active = go; exp_bus_we = 1'b0; exp_bus_addr = ba; exp_bus_be = be;
    exp_bus_wdata = bw; exp_bus_sel = sel;
    e.rd = rd; e.exc = exc;
    rsp_q.push_back(e);
    rsp_q.push_back(e);
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h0000_0010;
    bus_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 6; k++) begin
      rdy[k] = int'(req_ready);
      rv[k]  = int'(rsp_valid);
      bus_ack = bus_valid;
      if (k == 4) req_valid = 1'b0;
      @(negedge clk);
    end
    bus_ack = 1'b0;
    exp_bus_active = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("b2b_ready_%0d", k), 32'(rdy[k]), (k == 0 || k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_rsp_%0d", k), 32'(rv[k]), (k == 2 || k == 5) ? 32'd1 : 32'd0);
    end
    chk("b2b_all_responses", 32'(rsp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
